alu_exec_unit: RTL

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

---
 rtl/alu_exec_unit.sv | 120 ++++++++++++
 1 files changed

// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : alu_exec_unit
// Description : Single-issue ALU execution unit. ADD/SUB/SLT/AND/OR finish in
//               one edge. MUL is a WIDTH-iteration shift-and-add sequence that
//               holds the pipeline via stall/busy until the product is ready.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       ALU_control,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy,
  output logic             done,
  output logic             stall
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_MUL  = 2'b01;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_SLT = 3'b110;

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;

  logic [WIDTH-1:0] w_alu_val;
  logic [WIDTH-1:0] w_acc_next;
  logic             w_last_iter;
  logic             w_is_mul;

  assign w_is_mul    = (ALU_control == OP_MUL);
  assign w_acc_next  = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign w_last_iter = (r_cnt == CW'(WIDTH - 1));

  // Pipeline hold: asserted as soon as a MUL is being accepted, not one cycle late.
  assign stall = busy | (start & w_is_mul & (r_state == S_IDLE));

  // Single-cycle operations; unused/unlisted codes (011, 111) fall through to ADD.
  always_comb begin
    w_alu_val = src_a + src_b;
    case (ALU_control)
      OP_AND:  w_alu_val = src_a & src_b;
      OP_OR:   w_alu_val = src_a | src_b;
      OP_SUB:  w_alu_val = src_a - src_b;
      OP_SLT:  w_alu_val = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      default: w_alu_val = src_a + src_b;
    endcase
  end

  // Control FSM, multiplier datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      result   <= '0;
      zero     <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_is_mul) begin
              r_state  <= S_MUL;
              busy     <= 1'b1;
              r_cnt    <= '0;
              r_acc    <= '0;
              r_mcand  <= src_a;
              r_mplier <= src_b;
            end else begin
              result <= w_alu_val;
              zero   <= (w_alu_val == '0);
              done   <= 1'b1;
            end
          end
        end
        S_MUL: begin
          // Fixed WIDTH iterations: no early exit even when operands run out of ones.
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CW'(1);
          if (w_last_iter) begin
            result  <= w_acc_next;
            zero    <= (w_acc_next == '0);
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
